mem_access_unit: RTL and testbench

//   Initiator side of the CPU data-memory interface. Accepts load/store requests from the
//   MEM stage over a valid/ready handshake and drives a word-addressed data memory
//   (comb read, sync word write, no byte enables). Sub-word stores use read-modify-write.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator: takes load/store requests from the MEM stage, drives a
// word-addressed memory (sub-word stores by read-modify-write) and returns a response.
module mem_access_unit #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [31:0] req_pc_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  output logic [31:0] mem_pc_o,
  input  logic [31:0] mem_rd_i
);

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SB  = 3'b110;
  localparam logic [2:0] OP_SH  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_WR, S_RESP} state_e;

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [W-1:0]   wd_q, wd_d;

  logic           req_err_c;
  logic [4:0]     lane_sh_c;
  logic [W-1:0]   rd_shift_c;
  logic [W-1:0]   lane_mask_c;
  logic [W-1:0]   lane_data_c;
  logic [W-1:0]   load_data_c;

  // Alignment and range check on the incoming request
  always_comb begin
    req_err_c = 1'b0;
    case (req_op_i)
      OP_LH, OP_LHU, OP_SH: req_err_c = req_addr_i[0];
      OP_LW, OP_SW:         req_err_c = |req_addr_i[1:0];
      default:              req_err_c = 1'b0;
    endcase
    if (req_addr_i >= ADDR_LIMIT) req_err_c = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_sh_c   = {addr_q[1:0], 3'b000};
    rd_shift_c  = mem_rd_i >> lane_sh_c;
    lane_mask_c = '0;
    lane_data_c = '0;
    load_data_c = mem_rd_i;
    case (op_q)
      OP_LB:  load_data_c = {{24{rd_shift_c[7]}}, rd_shift_c[7:0]};
      OP_LBU: load_data_c = W'(rd_shift_c[7:0]);
      OP_LH:  load_data_c = {{16{rd_shift_c[15]}}, rd_shift_c[15:0]};
      OP_LHU: load_data_c = W'(rd_shift_c[15:0]);
      default: load_data_c = mem_rd_i;
    endcase
    if (op_q == OP_SB) begin
      lane_mask_c = W'(32'h0000_00FF) << lane_sh_c;
      lane_data_c = W'(wdata_q[7:0]) << lane_sh_c;
    end else begin
      lane_mask_c = W'(32'h0000_FFFF) << lane_sh_c;
      lane_data_c = W'(wdata_q[15:0]) << lane_sh_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          pc_d    = req_pc_i;
          rdata_d = '0;
          err_d   = req_err_c;
          if (req_err_c) begin
            state_d = S_RESP;
          end else if (req_op_i == OP_SW) begin
            wd_d    = req_wdata_i;
            state_d = S_WR;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (op_q == OP_SB || op_q == OP_SH) begin
          wd_d    = (mem_rd_i & ~lane_mask_c) | lane_data_c;
          state_d = S_WR;
        end else begin
          rdata_d = load_data_c;
          state_d = S_RESP;
        end
      end
      S_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wd_o     = wd_q;
  assign mem_pc_o     = pc_q;
  // Gating with reset drops a store caught mid-write
  assign mem_we_o     = (state_q == S_WR) & ~reset;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr, mem_wd, mem_pc, mem_rd;
  logic        mem_we;

  logic [31:0] mem [0:4095];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwr;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int we_cnt = 0;
  logic [31:0] w_addr, w_wd, w_pc;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_i     (req_op),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_pc_i     (req_pc),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_we_o     (mem_we),
    .mem_pc_o     (mem_pc),
    .mem_rd_i     (mem_rd)
  );

  assign mem_rd = mem[mem_addr[13:2]];

  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr[13:2]] <= mem_wd;

  // Capture every write strobe seen mid-cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt = we_cnt + 1;
      w_addr = mem_addr;
      w_wd   = mem_wd;
      w_pc   = mem_pc;
    end
  end

  // Drive one request through the handshake, then count cycles to resp_valid
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] pc, output int lat);
    int n;
    req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset.req_ready got %b want 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset.resp_valid got %b want 0", resp_valid); end
    n_vec++; if (resp_err !== 1'b0 || resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset.resp got err=%b rdata=%h want 0/0", resp_err, resp_rdata); end
    n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset.mem_we got %b want 0", mem_we); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    exp_t e;
    int lat, w0;
    w0 = we_cnt;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 2, nwr: 1, waddr: 32'h10, wd: 32'hDEADBEEF, pc: 32'h400});
    send(3'b101, 32'h10, 32'hDEADBEEF, 32'h400, lat);
    e = sb_q.pop_front();
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL sw.latency got %0d want %0d", lat, e.lat); end
    n_vec++; if (resp_err !== e.err || resp_rdata !== e.rdata) begin n_bad++; $display("FAIL sw.resp got err=%b rdata=%h want %b/%h", resp_err, resp_rdata, e.err, e.rdata); end
    n_vec++; if (we_cnt - w0 != e.nwr) begin n_bad++; $display("FAIL sw.we_count got %0d want %0d", we_cnt - w0, e.nwr); end
    n_vec++; if (w_addr !== e.waddr || w_wd !== e.wd || w_pc !== e.pc) begin n_bad++; $display("FAIL sw.write got a=%h d=%h pc=%h want %h/%h/%h", w_addr, w_wd, w_pc, e.waddr, e.wd, e.pc); end
    consume();
  endtask

  task automatic test_loads();
    logic [2:0]  ops  [7];
    logic [31:0] adrs [7];
    logic [31:0] exps [7];
    exp_t e;
    int lat, w0;
    ops  = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b001, 3'b010};
    adrs = '{32'h11, 32'h13, 32'h12, 32'h10, 32'h10, 32'h2FFF, 32'h12};
    exps = '{32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB, 32'h0000007F, 32'h00000099};
    mem[4]     = 32'h8899AABB;
    mem[12'hBFF] = 32'h7F000000;
    for (int i = 0; i < 7; i++) begin
      w0 = we_cnt;
      sb_q.push_back('{rdata: exps[i], err: 1'b0, lat: 2, nwr: 0, waddr: 32'h0, wd: 32'h0, pc: 32'h0});
      send(ops[i], adrs[i], 32'h5555_5555, 32'h1000 + 32'(i * 4), lat);
      e = sb_q.pop_front();
      n_vec++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL load[%0d].rdata got %h want %h", i, resp_rdata, e.rdata); end
      n_vec++; if (resp_err !== e.err) begin n_bad++; $display("FAIL load[%0d].err got %b want %b", i, resp_err, e.err); end
      n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL load[%0d].latency got %0d want %0d", i, lat, e.lat); end
      n_vec++; if (we_cnt - w0 != e.nwr) begin n_bad++; $display("FAIL load[%0d].we_count got %0d want %0d", i, we_cnt - w0, e.nwr); end
      consume();
    end
  endtask

  task automatic test_subword_store();
    logic [2:0]  ops  [3];
    logic [31:0] adrs [3];
    logic [31:0] wds  [3];
    logic [31:0] exps [3];
    exp_t e;
    int lat, w0;
    ops  = '{3'b110, 3'b111, 3'b110};
    adrs = '{32'h22, 32'h20, 32'h23};
    wds  = '{32'h000000EE, 32'h0000CAFE, 32'hFFFFFF5A};
    exps = '{32'h11EE3344, 32'h1122CAFE, 32'h5A223344};
    for (int i = 0; i < 3; i++) begin
      mem[8] = 32'h11223344;
      w0 = we_cnt;
      sb_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 3, nwr: 1, waddr: 32'h20, wd: exps[i], pc: 32'h2000 + 32'(i)});
      send(ops[i], adrs[i], wds[i], 32'h2000 + 32'(i), lat);
      e = sb_q.pop_front();
      n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL sub[%0d].latency got %0d want %0d", i, lat, e.lat); end
      n_vec++; if (resp_err !== e.err || resp_rdata !== e.rdata) begin n_bad++; $display("FAIL sub[%0d].resp got err=%b rdata=%h want %b/%h", i, resp_err, resp_rdata, e.err, e.rdata); end
      n_vec++; if (we_cnt - w0 != e.nwr) begin n_bad++; $display("FAIL sub[%0d].we_count got %0d want %0d", i, we_cnt - w0, e.nwr); end
      n_vec++; if (w_addr !== e.waddr || w_wd !== e.wd || w_pc !== e.pc) begin n_bad++; $display("FAIL sub[%0d].write got a=%h d=%h pc=%h want %h/%h/%h", i, w_addr, w_wd, w_pc, e.waddr, e.wd, e.pc); end
      n_vec++; if (mem[8] !== e.wd) begin n_bad++; $display("FAIL sub[%0d].mem got %h want %h", i, mem[8], e.wd); end
      consume();
    end
  endtask

  task automatic test_errors();
    logic [2:0]  ops  [5];
    logic [31:0] adrs [5];
    exp_t e;
    int lat, w0;
    ops  = '{3'b000, 3'b111, 3'b101, 3'b010, 3'b100};
    adrs = '{32'h06, 32'h03, 32'h3000, 32'hFFFF_FFF0, 32'h11};
    for (int i = 0; i < 5; i++) begin
      w0 = we_cnt;
      sb_q.push_back('{rdata: 32'h0, err: 1'b1, lat: 1, nwr: 0, waddr: 32'h0, wd: 32'h0, pc: 32'h0});
      send(ops[i], adrs[i], 32'hA5A5A5A5, 32'h3000, lat);
      e = sb_q.pop_front();
      n_vec++; if (resp_err !== e.err) begin n_bad++; $display("FAIL err[%0d].err got %b want %b", i, resp_err, e.err); end
      n_vec++; if (resp_rdata !== e.rdata) begin n_bad++; $display("FAIL err[%0d].rdata got %h want %h", i, resp_rdata, e.rdata); end
      n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL err[%0d].latency got %0d want %0d", i, lat, e.lat); end
      n_vec++; if (we_cnt - w0 != e.nwr) begin n_bad++; $display("FAIL err[%0d].we_count got %0d want %0d", i, we_cnt - w0, e.nwr); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    sb_q.push_back('{rdata: 32'h8899AABB, err: 1'b0, lat: 2, nwr: 0, waddr: 32'h0, wd: 32'h0, pc: 32'h0});
    send(3'b000, 32'h10, 32'h0, 32'h5000, lat);
    e = sb_q.pop_front();
    n_vec++; if (lat != e.lat) begin n_bad++; $display("FAIL bp.latency got %0d want %0d", lat, e.lat); end
    req_op = 3'b010; req_addr = 32'h13; req_wdata = 32'h0; req_pc = 32'h5004; req_valid = 1'b1;
    sb_q.push_back('{rdata: 32'h00000088, err: 1'b0, lat: 2, nwr: 0, waddr: 32'h0, wd: 32'h0, pc: 32'h0});
    for (int c = 0; c < 5; c++) begin
      n_vec++; if (resp_valid !== 1'b1 || resp_rdata !== e.rdata) begin n_bad++; $display("FAIL bp.hold[%0d] got v=%b rdata=%h want 1/%h", c, resp_valid, resp_rdata, e.rdata); end
      n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp.req_ready[%0d] got %b want 0", c, req_ready); end
      @(posedge clk); #1;
    end
    consume();
    n_vec++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL bp.after_consume got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp.second_accept got rdy=%b want 0", req_ready); end
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    if (resp_valid !== 1'b1) lat = -1;
    e = sb_q.pop_front();
    n_vec++; if (lat != e.lat || resp_rdata !== e.rdata) begin n_bad++; $display("FAIL bp.second got lat=%0d rdata=%h want %0d/%h", lat, resp_rdata, e.lat, e.rdata); end
    consume();
  endtask

  task automatic test_reset_in_wr();
    int w0;
    mem[8] = 32'h11223344;
    w0 = we_cnt;
    req_op = 3'b110; req_addr = 32'h22; req_wdata = 32'h77; req_pc = 32'h6000; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rstwr.mem_we got %b want 0", mem_we); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_vec++; if (we_cnt != w0) begin n_bad++; $display("FAIL rstwr.we_count got %0d want %0d", we_cnt - w0, 0); end
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstwr.state got rdy=%b v=%b want 1/0", req_ready, resp_valid); end
    n_vec++; if (mem[8] !== 32'h11223344) begin n_bad++; $display("FAIL rstwr.mem got %h want %h", mem[8], 32'h11223344); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = 3'b000; req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    test_reset();
    test_sw();
    test_loads();
    test_subword_store();
    test_errors();
    test_backpressure();
    test_reset_in_wr();
    n_vec++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL scoreboard.leftover got %0d want 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
